// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Optional FIFO_ARB_STATS_EN adds saturating grant counters.
// Revision: 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arb_en,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_overflow,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  output logic                            err_overflow,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      last_q, last_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
  logic                  err_overflow_q, err_overflow_d;

  logic                  allow;
  logic                  found;
  logic                  grant;
  logic [IDX_W-1:0]      win;
  logic [IDX_W-1:0]      idx;
  logic [NUM_REQ-1:0]    gnt_w;

  // The almost-full term covers a registered write the FIFO flags do not show yet.
  always_comb begin
    allow = arb_en && !rst && !fifo_full && !(fifo_wr_en_q && fifo_almostfull);
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    gnt_w = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant = allow && found;
    if (grant) begin
      gnt_w[win] = 1'b1;
    end
  end

  always_comb begin
    last_d         = last_q;
    fifo_wr_en_d   = grant;
    fifo_data_in_d = fifo_data_in_q;
    err_overflow_d = err_overflow_q | fifo_overflow;
    if (grant) begin
      last_d         = win;
      fifo_data_in_d = req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q         <= IDX_W'(NUM_REQ - 1);
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      last_q         <= last_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_data_in_q <= fifo_data_in_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign gnt          = gnt_w;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_in_q;
  assign err_overflow = err_overflow_q;

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_w[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_arbiter : directed-vector bench for fifo_wr_arbiter.
// Revision: 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;
`ifdef FIFO_ARB_STATS_EN
  localparam int CNT_WIDTH  = 4;
`else
  localparam int CNT_WIDTH  = 16;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          arb_en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          err_overflow;
  logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .FIFO_WIDTH(FIFO_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_en         (arb_en),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_full      (fifo_full),
    .fifo_almostfull(fifo_almostfull),
    .fifo_overflow  (fifo_overflow),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_data_in   (fifo_data_in),
    .err_overflow   (err_overflow),
    .grant_cnt      (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are checked at posedge+2 or later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CNT_WIDTH-1:0] cnt2;

  initial begin
    rst             = 1'b1;
    arb_en          = 1'b1;
    req             = 4'b1111;
    fifo_full       = 1'b0;
    fifo_almostfull = 1'b0;
    fifo_overflow   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = 16'hA000 + 16'(i);
    end

    // Reset state
    tick();
    tick();
    #1;
    check_val("rst_gnt",     64'(gnt), 64'h0);
    check_val("rst_wr_en",   64'(fifo_wr_en), 64'h0);
    check_val("rst_data",    64'(fifo_data_in), 64'h0);
    check_val("rst_err",     64'(err_overflow), 64'h0);
    check_val("rst_cnt",     64'(grant_cnt), 64'h0);

    // Fairness: all four requesting
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check_val("fair_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
      tick();
      #1;
      check_val("fair_wr_en", 64'(fifo_wr_en), 64'h1);
      check_val("fair_data",  64'(fifo_data_in), 64'(16'hA000 + 16'(i % 4)));
    end

    // Skip idle producers: set last=1, then only 0 and 3 request
    req = 4'b0010;
    #1;
    check_val("skip_gnt1", 64'(gnt), 64'h2);
    tick();
    req = 4'b1001;
    #1;
    check_val("skip_gnt3a", 64'(gnt), 64'h8);
    tick();
    #1;
    check_val("skip_data3", 64'(fifo_data_in), 64'hA003);
    check_val("skip_gnt0",  64'(gnt), 64'h1);
    tick();
    #1;
    check_val("skip_data0", 64'(fifo_data_in), 64'hA000);
    check_val("skip_gnt3b", 64'(gnt), 64'h8);
    tick();

    // arb_en low blocks new grants
    arb_en = 1'b0;
    req    = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("dis_gnt", 64'(gnt), 64'h0);
      tick();
      #1;
      check_val("dis_wr_en", 64'(fifo_wr_en), 64'h0);
    end
    arb_en = 1'b1;
    #1;
    check_val("en_gnt", 64'(gnt), 64'h4);
    tick();
    #1;
    check_val("en_wr_en", 64'(fifo_wr_en), 64'h1);
    check_val("en_data",  64'(fifo_data_in), 64'hA002);

    // Backpressure: FIFO of depth 8 holding 7 words
    req = 4'b0000;
    tick();
    fifo_almostfull = 1'b1;
    req             = 4'b0011;
    #1;
    check_val("bp_gnt_first", 64'(gnt), 64'h1);
    tick();
    #1;
    check_val("bp_wr_en",     64'(fifo_wr_en), 64'h1);
    check_val("bp_data",      64'(fifo_data_in), 64'hA000);
    check_val("bp_gnt_inflt", 64'(gnt), 64'h0);
    tick();
    fifo_full       = 1'b1;
    fifo_almostfull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_full_gnt",   64'(gnt), 64'h0);
      check_val("bp_full_wr_en", 64'(fifo_wr_en), 64'h0);
      tick();
    end
    check_val("bp_no_ovf", 64'(err_overflow), 64'h0);
    fifo_full = 1'b0;
    #1;
    check_val("bp_resume_gnt", 64'(gnt), 64'h2);
    tick();

    // Sustained single producer: 20 grants to producer 2
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt !== 4'b0100) begin
        check_val("single_gnt", 64'(gnt), 64'h4);
      end
      tick();
    end
    n_vec++;
    #1;
    cnt2 = grant_cnt[2*CNT_WIDTH +: CNT_WIDTH];
`ifdef FIFO_ARB_STATS_EN
    check_val("cnt2_sat", 64'(cnt2), 64'hF);
`else
    check_val("cnt2_tied", 64'(cnt2), 64'h0);
`endif
    check_val("single_wr_en", 64'(fifo_wr_en), 64'h1);

    // Overflow pulse makes err_overflow sticky
    req           = 4'b0000;
    fifo_overflow = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    #1;
    check_val("ovf_set", 64'(err_overflow), 64'h1);
    tick();
    tick();
    check_val("ovf_sticky", 64'(err_overflow), 64'h1);

    // Asynchronous reset mid-write
    req = 4'b0100;
    tick();
    #1;
    check_val("pre_rst_wr_en", 64'(fifo_wr_en), 64'h1);
    rst = 1'b1;
    #1;
    check_val("async_wr_en", 64'(fifo_wr_en), 64'h0);
    check_val("async_gnt",   64'(gnt), 64'h0);
    check_val("async_err",   64'(err_overflow), 64'h0);
    check_val("async_cnt",   64'(grant_cnt), 64'h0);
    tick();
    rst = 1'b0;
    req = 4'b1111;
    #1;
    check_val("post_rst_gnt", 64'(gnt), 64'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of one synchronous FIFO among NUM_REQ independent producers. Each producer holds a request with its data word; the arbiter grants at most one per cycle, registers the winning word onto the FIFO write port, and never issues a write the FIFO cannot absorb. Sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- NUM_REQ, 4: number of producers (2..8)
- FIFO_WIDTH, 16: data word width, matches the FIFO
- CNT_WIDTH, 16: width of each per-producer grant counter (stats build only)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- arb_en  input  1  1 = grants allowed; 0 = no new grants
- req  input  NUM_REQ  per-producer request, held until granted
- req_data  input  NUM_REQ*FIFO_WIDTH  producer i word at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  output  NUM_REQ  combinational one-hot grant; word accepted at this clock edge
- fifo_full  input  1  FIFO full flag
- fifo_almostfull  input  1  FIFO almost-full flag (one slot left)
- fifo_overflow  input  1  FIFO overflow pulse
- fifo_wr_en  output  1  registered FIFO write enable
- fifo_data_in  output  FIFO_WIDTH  registered FIFO write data
- err_overflow  output  1  sticky: FIFO reported overflow since reset
- grant_cnt  output  NUM_REQ*CNT_WIDTH  per-producer grant counts (see Configuration)

## Operation
- Handshake: req[i] with req_data valid; transfer when req[i] && gnt[i] in the same cycle. Producer must not drop req or change data before grant; may present next word the cycle after grant.
- Allow = arb_en && !fifo_full && !(fifo_wr_en && fifo_almostfull). Second term covers the in-flight write the FIFO flags do not yet reflect.
- Arbitration: state `last` (index of last granted producer). Search order last+1, last+2, ... wrapping mod NUM_REQ; first asserted req wins when Allow. gnt = 0 when Allow=0 or req=0.
- `last` updates to the winner only on a grant; unchanged otherwise.
- On grant edge: fifo_wr_en <= 1, fifo_data_in <= winner's word. No grant: fifo_wr_en <= 0, fifo_data_in holds its value.
- err_overflow sets on any fifo_overflow=1 sample, clears only by rst.
- Reset values: last = NUM_REQ-1 (producer 0 highest priority first), fifo_wr_en = 0, fifo_data_in = 0, err_overflow = 0, grant_cnt = 0. gnt is combinational and 0 while rst is high.

## Timing
- Request in cycle N with Allow -> gnt in cycle N -> fifo_wr_en=1 with data in N+1 -> FIFO stores at edge ending N+1.
- Throughput: one write per cycle while FIFO has ≥2 free slots; with one free slot, one write then a one-cycle gap before Allow re-evaluates.
- arb_en falling: no grant that cycle; an already-registered write still issues next cycle.
- Same producer requesting continuously alongside others gets every NUM_REQ-th grant; single active producer gets every cycle.
- Async rst mid-operation: fifo_wr_en drops immediately; a word granted in the cycle before rst but not yet written is lost (producer already saw gnt).

## Configuration
- FIFO_ARB_STATS_EN defined: per-producer saturating CNT_WIDTH counters, increment on each gnt[i], stick at all-ones, cleared by rst; driven on grant_cnt.
- Undefined: no counters instantiated; grant_cnt tied to 0. Port list identical in both builds.

## Test plan
- Reset: rst=1 with req=4'b1111 -> gnt=0, fifo_wr_en=0, fifo_data_in=0, err_overflow=0; first grant after release goes to producer 0.
- Fairness: req=4'b1111 held, words 0xA000+i, FIFO never full -> gnt sequence 0,1,2,3,0,... and fifo_data_in 0xA000,0xA001,0xA002,0xA003 one per cycle.
- Backpressure: FIFO depth 8 pre-filled to 7, req=4'b0011 -> exactly one write, then gnt=0 while fifo_full=1; fifo_overflow never asserts.
- Skip idle: last=1, req=4'b1001 -> grant 3, then 0, then 3; producers 1,2 never granted.
- arb_en=0 for 5 cycles with req=4'b0100 -> gnt=0, fifo_wr_en=0; arb_en=1 -> gnt=4'b0100 same cycle, write next cycle.
- Stats (FIFO_ARB_STATS_EN, CNT_WIDTH=4): 20 grants to producer 2 -> grant_cnt[2] saturates at 0xF; injected fifo_overflow pulse -> err_overflow=1 until rst.
